// File: rtl/mcu_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// States, opcode/funct values, ALUOp and ALU control codes.
package mcu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXECUTE,
        S_ALUWB,
        S_BRANCH,
        S_ADDIEX,
        S_ADDIWB,
        S_JUMP,
        S_HALT
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALUCTL_ADD = 3'b010;
    localparam logic [2:0] ALUCTL_SUB = 3'b110;
    localparam logic [2:0] ALUCTL_AND = 3'b000;
    localparam logic [2:0] ALUCTL_OR  = 3'b001;
    localparam logic [2:0] ALUCTL_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// ALUOp/funct to ALU control decode; unknown funct and reserved
// ALUOp both fall back to add.
module alu_decoder
    import mcu_pkg::*;
#(
    parameter int ALUOP_W  = 2,
    parameter int ALUCTL_W = 3
) (
    input  logic [ALUOP_W-1:0]  alu_op_i,
    input  logic [5:0]          funct_i,
    output logic [ALUCTL_W-1:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALUCTL_W'(ALUCTL_ADD);
        case (alu_op_i)
            ALUOP_W'(ALUOP_SUB): alu_control_o = ALUCTL_W'(ALUCTL_SUB);
            ALUOP_W'(ALUOP_FUNCT): begin
                case (funct_i)
                    FN_SUB:  alu_control_o = ALUCTL_W'(ALUCTL_SUB);
                    FN_AND:  alu_control_o = ALUCTL_W'(ALUCTL_AND);
                    FN_OR:   alu_control_o = ALUCTL_W'(ALUCTL_OR);
                    FN_SLT:  alu_control_o = ALUCTL_W'(ALUCTL_SLT);
                    default: alu_control_o = ALUCTL_W'(ALUCTL_ADD);
                endcase
            end
            default: alu_control_o = ALUCTL_W'(ALUCTL_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory-ready handshake, ADDI/J,
// illegal-opcode detection and an embedded ALU decoder.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int ALUOP_W         = 2,
    parameter int ALUCTL_W        = 3,
    parameter int EN_ADDI         = 1,
    parameter int EN_JUMP         = 1,
    parameter int HALT_ON_ILLEGAL = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          op,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                ir_write,
    output logic                mem_write,
    output logic                pc_en,
    output logic [1:0]          pc_src,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                illegal_op,
    output logic                halted
);

    state_t state_q, state_d;
    state_t dec_next;
    logic   op_ok;
    logic   pc_write;
    logic   branch;
    logic [ALUOP_W-1:0] alu_op;

    always_comb begin
        dec_next = S_FETCH;
        op_ok    = 1'b1;
        case (op)
            OP_LW, OP_SW: dec_next = S_MEMADR;
            OP_RTYPE:     dec_next = S_EXECUTE;
            OP_BEQ:       dec_next = S_BRANCH;
            OP_ADDI: begin
                if (EN_ADDI != 0) dec_next = S_ADDIEX;
                else op_ok = 1'b0;
            end
            OP_J: begin
                if (EN_JUMP != 0) dec_next = S_JUMP;
                else op_ok = 1'b0;
            end
            default: op_ok = 1'b0;
        endcase
        if (!op_ok) dec_next = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
            S_DECODE:  state_d = dec_next;
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:   if (mem_ready) state_d = S_FETCH;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_HALT:    state_d = S_HALT;
            default:   state_d = S_FETCH;
        endcase
    end

    // Reset gates every output combinationally so no strobe leaks
    // while reset is held, even though the state already reads FETCH.
    always_comb begin
        mem_req    = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        mem_write  = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = PCSRC_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALUOP_W'(ALUOP_ADD);
        illegal_op = 1'b0;
        halted     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = SRCB_IMMSH;
                    illegal_op = ~op_ok;
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_MEMWB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                S_EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_W'(ALUOP_FUNCT);
                end
                S_ALUWB: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_W'(ALUOP_SUB);
                    pc_src    = PCSRC_ALUOUT;
                    branch    = 1'b1;
                end
                S_ADDIWB:  reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = PCSRC_JUMP;
                    pc_write = 1'b1;
                end
                S_HALT:    halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign pc_en = pc_write | (branch & zero);

    alu_decoder #(
        .ALUOP_W  (ALUOP_W),
        .ALUCTL_W (ALUCTL_W)
    ) u_alu_dec (
        .alu_op_i      (alu_op),
        .funct_i       (funct),
        .alu_control_o (alu_control)
    );

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: three instances (default, halt-on-illegal, no-jump)
// share stimulus; expected output vectors are queued per cycle.
module tb_multicycle_control_unit;

    typedef struct {
        string       name;
        int          sel;
        logic [17:0] exp;
    } exp_t;

    // {mem_req,iord,ir_write,mem_write,pc_en,pc_src,alu_src_a,alu_src_b,
    //  reg_dst,mem_to_reg,reg_write,alu_control,illegal_op,halted}
    localparam logic [17:0] E_RST  = 18'b0_0_0_0_0_00_0_00_0_0_0_010_0_0;
    localparam logic [17:0] E_FRDY = 18'b1_0_1_0_1_00_0_01_0_0_0_010_0_0;
    localparam logic [17:0] E_FWT  = 18'b1_0_0_0_0_00_0_01_0_0_0_010_0_0;
    localparam logic [17:0] E_DEC  = 18'b0_0_0_0_0_00_0_11_0_0_0_010_0_0;
    localparam logic [17:0] E_DILL = 18'b0_0_0_0_0_00_0_11_0_0_0_010_1_0;
    localparam logic [17:0] E_MADR = 18'b0_0_0_0_0_00_1_10_0_0_0_010_0_0;
    localparam logic [17:0] E_MRD  = 18'b1_1_0_0_0_00_0_00_0_0_0_010_0_0;
    localparam logic [17:0] E_MWR  = 18'b1_1_0_1_0_00_0_00_0_0_0_010_0_0;
    localparam logic [17:0] E_MWB  = 18'b0_0_0_0_0_00_0_00_0_1_1_010_0_0;
    localparam logic [17:0] E_AWB  = 18'b0_0_0_0_0_00_0_00_1_0_1_010_0_0;
    localparam logic [17:0] E_BRZ  = 18'b0_0_0_0_1_01_1_00_0_0_0_110_0_0;
    localparam logic [17:0] E_BRN  = 18'b0_0_0_0_0_01_1_00_0_0_0_110_0_0;
    localparam logic [17:0] E_AIWB = 18'b0_0_0_0_0_00_0_00_0_0_1_010_0_0;
    localparam logic [17:0] E_JMP  = 18'b0_0_0_0_1_10_0_00_0_0_0_010_0_0;
    localparam logic [17:0] E_HALT = 18'b0_0_0_0_0_00_0_00_0_0_0_010_0_1;

    logic clk = 1'b0;
    logic reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic zero;
    logic mem_ready;
    wire [2:0][17:0] obs;

    exp_t sb[$];
    exp_t it;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        multicycle_control_unit #(
            .EN_JUMP         ((g == 2) ? 0 : 1),
            .HALT_ON_ILLEGAL ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk         (clk),
            .reset       (reset),
            .op          (op),
            .funct       (funct),
            .zero        (zero),
            .mem_ready   (mem_ready),
            .mem_req     (obs[g][17]),
            .iord        (obs[g][16]),
            .ir_write    (obs[g][15]),
            .mem_write   (obs[g][14]),
            .pc_en       (obs[g][13]),
            .pc_src      (obs[g][12:11]),
            .alu_src_a   (obs[g][10]),
            .alu_src_b   (obs[g][9:8]),
            .reg_dst     (obs[g][7]),
            .mem_to_reg  (obs[g][6]),
            .reg_write   (obs[g][5]),
            .alu_control (obs[g][4:2]),
            .illegal_op  (obs[g][1]),
            .halted      (obs[g][0])
        );
    end

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            it = sb.pop_front();
            total++;
            if (obs[it.sel] !== it.exp) begin
                bad++;
                $display("FAIL %s dut%0d got=%b exp=%b",
                         it.name, it.sel, obs[it.sel], it.exp);
            end
        end
    end

    function automatic logic [17:0] ex(input logic [2:0] c);
        return {13'b0_0_0_0_0_00_1_00_0_0_0, c, 2'b00};
    endfunction

    task automatic push(input int s, input logic [17:0] e, input string nm);
        exp_t x;
        x.name = nm;
        x.sel  = s;
        x.exp  = e;
        sb.push_back(x);
    endtask

    task automatic cyc(input logic r, input logic [5:0] o,
                       input logic [5:0] f, input logic z,
                       input logic rdy, input logic [17:0] e0,
                       input string nm);
        reset     = r;
        op        = o;
        funct     = f;
        zero      = z;
        mem_ready = rdy;
        push(0, e0, nm);
        @(posedge clk);
        #1;
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] c);
        cyc(0, 6'b000000, f, 0, 1, E_FRDY, "r_fetch");
        cyc(0, 6'b000000, f, 0, 1, E_DEC,  "r_decode");
        cyc(0, 6'b000000, f, 0, 1, ex(c),  "r_execute");
        cyc(0, 6'b000000, f, 0, 1, E_AWB,  "r_aluwb");
    endtask

    initial begin
        reset = 1'b1;
        op = 6'b0;
        funct = 6'b0;
        zero = 1'b0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        push(1, E_RST, "reset_h");
        push(2, E_RST, "reset_nj");
        cyc(1, 6'b000000, 6'b100000, 0, 1, E_RST, "reset");

        rtype(6'b100000, 3'b010);
        rtype(6'b100010, 3'b110);
        rtype(6'b100100, 3'b000);
        rtype(6'b100101, 3'b001);
        rtype(6'b101010, 3'b111);
        rtype(6'b000111, 3'b010);

        // lw with two wait cycles in MEMRD: MEMWB lands in cycle 7
        cyc(0, 6'b100011, 0, 0, 1, E_FRDY, "lw_fetch");
        cyc(0, 6'b100011, 0, 0, 1, E_DEC,  "lw_decode");
        cyc(0, 6'b100011, 0, 0, 1, E_MADR, "lw_memadr");
        cyc(0, 6'b100011, 0, 0, 0, E_MRD,  "lw_memrd_w1");
        cyc(0, 6'b100011, 0, 0, 0, E_MRD,  "lw_memrd_w2");
        cyc(0, 6'b100011, 0, 0, 1, E_MRD,  "lw_memrd_rdy");
        cyc(0, 6'b100011, 0, 0, 1, E_MWB,  "lw_memwb_c7");
        cyc(0, 6'b100011, 0, 0, 0, E_FWT,  "lw_after_wb");

        // sw with fetch stall and one write wait
        cyc(0, 6'b101011, 0, 0, 1, E_FRDY, "sw_fetch");
        cyc(0, 6'b101011, 0, 0, 1, E_DEC,  "sw_decode");
        cyc(0, 6'b101011, 0, 0, 1, E_MADR, "sw_memadr");
        cyc(0, 6'b101011, 0, 0, 0, E_MWR,  "sw_memwr_w");
        cyc(0, 6'b101011, 0, 0, 1, E_MWR,  "sw_memwr_rdy");
        cyc(0, 6'b101011, 0, 0, 0, E_FWT,  "sw_next_fetch");

        // reset raised while stalled in MEMWR
        cyc(0, 6'b101011, 0, 0, 1, E_FRDY, "swr_fetch");
        cyc(0, 6'b101011, 0, 0, 1, E_DEC,  "swr_decode");
        cyc(0, 6'b101011, 0, 0, 1, E_MADR, "swr_memadr");
        cyc(0, 6'b101011, 0, 0, 0, E_MWR,  "swr_memwr");
        cyc(1, 6'b101011, 0, 0, 0, E_RST,  "swr_async_rst");
        cyc(1, 6'b101011, 0, 0, 1, E_RST,  "swr_rst_hold");
        cyc(0, 6'b101011, 0, 0, 0, E_FWT,  "swr_release");

        cyc(0, 6'b000100, 0, 1, 1, E_FRDY, "beq1_fetch");
        cyc(0, 6'b000100, 0, 1, 1, E_DEC,  "beq1_decode");
        cyc(0, 6'b000100, 0, 1, 1, E_BRZ,  "beq1_branch");
        cyc(0, 6'b000100, 0, 0, 1, E_FRDY, "beq0_fetch");
        cyc(0, 6'b000100, 0, 0, 1, E_DEC,  "beq0_decode");
        cyc(0, 6'b000100, 0, 0, 1, E_BRN,  "beq0_branch");

        cyc(0, 6'b001000, 0, 0, 1, E_FRDY, "addi_fetch");
        cyc(0, 6'b001000, 0, 0, 1, E_DEC,  "addi_decode");
        cyc(0, 6'b001000, 0, 0, 1, E_MADR, "addi_ex");
        cyc(0, 6'b001000, 0, 0, 1, E_AIWB, "addi_wb");

        cyc(0, 6'b111111, 0, 0, 1, E_FRDY, "ill_fetch");
        push(1, E_DILL, "ill_decode_h");
        push(2, E_DILL, "ill_decode_nj");
        cyc(0, 6'b111111, 0, 0, 1, E_DILL, "ill_decode");
        push(1, E_HALT, "ill_halt_h");
        cyc(0, 6'b111111, 0, 0, 1, E_FRDY, "ill_refetch");
        push(1, E_HALT, "ill_halt_hold_h");
        cyc(0, 6'b111111, 0, 0, 1, E_DILL, "ill_decode2");
        push(1, E_RST, "halt_reset_h");
        cyc(1, 6'b000010, 0, 0, 1, E_RST, "halt_reset");

        push(1, E_FRDY, "j_fetch_h");
        push(2, E_FRDY, "j_fetch_nj");
        cyc(0, 6'b000010, 0, 0, 1, E_FRDY, "j_fetch");
        push(1, E_DEC,  "j_decode_h");
        push(2, E_DILL, "j_decode_nj");
        cyc(0, 6'b000010, 0, 0, 1, E_DEC,  "j_decode");
        push(1, E_JMP,  "j_jump_h");
        push(2, E_FRDY, "j_refetch_nj");
        cyc(0, 6'b000010, 0, 0, 1, E_JMP,  "j_jump");
        cyc(0, 6'b000010, 0, 0, 0, E_FWT,  "j_next_fetch");

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain left=%0d need=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
